// File: rtl/sram_burst_reader_pkg.sv
// Shared types and helpers for the SRAM burst read initiator.
package sram_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A read may go out only if the buffer can still take its data one cycle later.
  function automatic logic issue_allowed(input logic [1:0] count,
                                         input logic       outstanding,
                                         input logic       pop);
    logic [2:0] occupancy;
    occupancy = {1'b0, count} + {2'b00, outstanding} - {2'b00, pop};
    return occupancy < 3'd2;
  endfunction

endpackage

// File: rtl/sram_burst_reader_if.sv
// Command, SRAM read port and output stream of the burst reader.
interface sram_burst_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int LEN_WIDTH  = 4
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]  cmd_len_i;
  logic                  mem_rd_en_o;
  logic [ADDR_WIDTH-1:0] mem_raddr_o;
  logic [DATA_WIDTH-1:0] mem_rd_data_i;
  logic                  dout_valid_o;
  logic                  dout_ready_i;
  logic [DATA_WIDTH-1:0] dout_data_o;
  logic                  dout_last_o;
  logic                  busy_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, mem_rd_data_i, dout_ready_i,
    output cmd_ready_o, mem_rd_en_o, mem_raddr_o, dout_valid_o, dout_data_o,
           dout_last_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, mem_rd_data_i, dout_ready_i,
    input  cmd_ready_o, mem_rd_en_o, mem_raddr_o, dout_valid_o, dout_data_o,
           dout_last_o, busy_o
  );
endinterface

// File: rtl/sram_burst_reader_skid.sv
// Two-entry FIFO of tagged words; caller never pushes into a full buffer without a pop.
module sram_burst_reader_skid #(
  parameter int WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_word,
  input  logic             pop,
  output logic [WIDTH-1:0] head_word,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] entry [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) entry[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= push_word;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_word = entry[rd_ptr];

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read initiator: issues SRAM reads and streams the words out with a last flag.
// state | meaning
// IDLE  | waiting for a command, cmd_ready_o high
// READ  | issuing reads whenever the buffer has room for the returning word
// DRAIN | every read issued, emptying the buffer up to the last beat
module sram_burst_reader
  import sram_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sram_burst_reader_if.master bus
);
  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH:0]    remaining;
  logic                  outstanding;
  logic                  pend_last;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH:0]   head_word;
  logic                  dout_valid;
  logic                  pop;
  logic                  issue;
  logic                  issue_last;

  assign dout_valid = (buf_count != 2'd0);
  assign pop        = dout_valid & bus.dout_ready_i;
  assign issue      = (state == ST_READ) & issue_allowed(buf_count, outstanding, pop);
  assign issue_last = issue & (remaining == (LEN_WIDTH+1)'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= 1'b0;
      pend_last   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      // The SRAM answers one cycle after an issue, so the in-flight read is just last cycle's issue.
      outstanding <= issue;
      pend_last   <= issue_last;
      if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - (LEN_WIDTH+1)'(1);
      end
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid_i) begin
            addr        <= bus.cmd_addr_i;
            remaining   <= {1'b0, bus.cmd_len_i} + (LEN_WIDTH+1)'(1);
            state       <= ST_READ;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop & head_word[DATA_WIDTH]) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sram_burst_reader_skid #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (outstanding),
    .push_word ({pend_last, bus.mem_rd_data_i}),
    .pop       (pop),
    .head_word (head_word),
    .count     (buf_count)
  );

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.mem_rd_en_o  = issue;
  assign bus.mem_raddr_o  = addr;
  assign bus.dout_valid_o = dout_valid;
  assign bus.dout_data_o  = head_word[DATA_WIDTH-1:0];
  assign bus.dout_last_o  = dout_valid & head_word[DATA_WIDTH];

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader against a 1-cycle-latency SRAM model.
module tb_sram_burst_reader;
  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  sram_burst_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .LEN_WIDTH(4)) bus ();

  sram_burst_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .LEN_WIDTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 16'h00A0 + 16'(i);

  always @(posedge clk_i) if (bus.mem_rd_en_o) bus.mem_rd_data_i <= mem[bus.mem_raddr_o];

  typedef struct {
    logic [2:0]  addr;
    logic [3:0]  len;
    int          mode;       // 0 ready high, 1 random ready, 2 ready low for 10 cycles
    logic [15:0] first_data;
    logic [15:0] last_data;
    int          lat;        // cycle of first beat when ready is high, 0 = not checked
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready_o, 1);
    check({tag, "_rd_en"},     bus.mem_rd_en_o, 0);
    check({tag, "_valid"},     bus.dout_valid_o, 0);
    check({tag, "_last"},      bus.dout_last_o, 0);
    check({tag, "_busy"},      bus.busy_o, 0);
    check({tag, "_data"},      bus.dout_data_o, 0);
    check({tag, "_raddr"},     bus.mem_raddr_o, 0);
  endtask

  task automatic run_burst(input vec_t v);
    int          nbeats, beats, issued, ahead, max_ahead, c;
    logic        held, held_last;
    logic [15:0] held_data, ed;
    logic [2:0]  ea, wa;
    nbeats = int'(v.len) + 1;
    c = 0;
    @(negedge clk_i);
    while (!bus.cmd_ready_o && c < 50) begin
      @(negedge clk_i);
      c++;
    end
    check("cmd_ready_before_burst", bus.cmd_ready_o, 1);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_addr_i   = v.addr;
    bus.cmd_len_i    = v.len;
    bus.dout_ready_i = (v.mode == 0);
    #1;
    check("busy_before_accept", bus.busy_o, 0);
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
    beats = 0; issued = 0; max_ahead = 0; held = 1'b0;
    for (c = 1; c <= 200 && beats < nbeats; c++) begin
      case (v.mode)
        0:       bus.dout_ready_i = 1'b1;
        1:       bus.dout_ready_i = 1'($urandom_range(0, 1));
        default: bus.dout_ready_i = (c > 10);
      endcase
      #1;
      if (held) begin
        check("hold_valid", bus.dout_valid_o, 1);
        check("hold_data",  bus.dout_data_o, held_data);
        check("hold_last",  bus.dout_last_o, held_last);
      end
      if (bus.mem_rd_en_o) begin
        ea = v.addr + 3'(issued);
        check("raddr", bus.mem_raddr_o, ea);
        issued++;
      end
      if (bus.dout_valid_o && bus.dout_ready_i) begin
        wa = v.addr + 3'(beats);
        ed = 16'h00A0 + {13'b0, wa};
        check("beat_data", bus.dout_data_o, ed);
        check("beat_last", bus.dout_last_o, beats == nbeats - 1);
        if (v.lat != 0) check("beat_cycle", c, v.lat + beats);
        if (beats == 0) check("first_data", bus.dout_data_o, v.first_data);
        if (beats == nbeats - 1) begin
          check("last_data", bus.dout_data_o, v.last_data);
          check("busy_at_last", bus.busy_o, 1);
        end
        beats++;
        held = 1'b0;
      end else if (bus.dout_valid_o) begin
        held      = 1'b1;
        held_data = bus.dout_data_o;
        held_last = bus.dout_last_o;
      end else begin
        held = 1'b0;
      end
      ahead = issued - beats;
      if (ahead > max_ahead) max_ahead = ahead;
      if (beats < nbeats) @(negedge clk_i);
    end
    check("beat_count", beats, nbeats);
    check("issue_count", issued, nbeats);
    check("max_ahead_le_2", max_ahead <= 2, 1);
    @(negedge clk_i);
    #1;
    check("busy_after_last", bus.busy_o, 0);
    check("cmd_ready_after_last", bus.cmd_ready_o, 1);
    check("valid_after_last", bus.dout_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stale, accepts, pops, viol;
    int          acc_c[2];
    logic [15:0] ed;

    vecs[0] = '{3'd3, 4'd0,  0, 16'h00A3, 16'h00A3, 3};
    vecs[1] = '{3'd0, 4'd7,  0, 16'h00A0, 16'h00A7, 3};
    vecs[2] = '{3'd6, 4'd3,  0, 16'h00A6, 16'h00A1, 3};
    vecs[3] = '{3'd0, 4'd7,  1, 16'h00A0, 16'h00A7, 0};
    vecs[4] = '{3'd0, 4'd7,  2, 16'h00A0, 16'h00A7, 0};
    vecs[5] = '{3'd7, 4'd15, 0, 16'h00A7, 16'h00A6, 3};

    rst_i = 1'b1;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_addr_i   = '0;
    bus.cmd_len_i    = '0;
    bus.dout_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check_reset_outputs("por");
    rst_i = 1'b0;

    // Reset in the middle of a burst
    @(negedge clk_i);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_addr_i   = 3'd2;
    bus.cmd_len_i    = 4'd5;
    bus.dout_ready_i = 1'b1;
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("pre_reset_valid", bus.dout_valid_o, 1);
    check("pre_reset_busy", bus.busy_o, 1);
    #1 rst_i = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_i);
    rst_i = 1'b0;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.dout_valid_o || bus.mem_rd_en_o || bus.busy_o) stale++;
      @(negedge clk_i);
    end
    check("no_stale_after_reset", stale, 0);

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // Command held valid through a burst: exactly one re-accept, one IDLE cycle apart
    @(negedge clk_i);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_addr_i   = 3'd1;
    bus.cmd_len_i    = 4'd2;
    bus.dout_ready_i = 1'b1;
    accepts = 0; pops = 0; viol = 0;
    acc_c[0] = -1; acc_c[1] = -1;
    for (int c = 0; c < 30; c++) begin
      if (accepts >= 2) bus.cmd_valid_i = 1'b0;
      #1;
      if (bus.cmd_valid_i && bus.cmd_ready_o) begin
        if (accepts < 2) acc_c[accepts] = c;
        accepts++;
      end
      if (bus.busy_o && bus.cmd_ready_o) viol++;
      if (bus.dout_valid_o && bus.dout_ready_i) begin
        ed = 16'h00A1 + 16'(pops % 3);
        check("held_cmd_data", bus.dout_data_o, ed);
        check("held_cmd_last", bus.dout_last_o, (pops % 3) == 2);
        pops++;
      end
      @(negedge clk_i);
    end
    check("held_cmd_accepts", accepts, 2);
    check("held_cmd_first_accept", acc_c[0], 0);
    check("held_cmd_second_accept", acc_c[1], 6);
    check("held_cmd_beats", pops, 6);
    check("held_cmd_ready_while_busy", viol, 0);
    #1;
    check("held_cmd_idle_at_end", bus.cmd_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
